pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central hazard and stall sequencer for the 5-stage RV32I core (IF/ID/EX/MEM/WB); branches resolve in ID.
- Drives per-stage write enables, bubble and flush controls from ID-stage decode and the downstream pipeline-register fields.
- Owns the 2-cycle load→branch stall via an FSM, the post-reset fetch warm-up, and a global freeze while data memory is busy.
- Carries saturating performance counters for stall, flush and freeze cycles.

Parameters:
REG_ADDR_LEN, 5, register address width
BOOT_CYCLES, 2, cycles of fetch warm-up after reset (1..15)
CNT_WIDTH, 32, width of each performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  reset; async assert, sync deassert
id_rs1_addr  in  REG_ADDR_LEN  rs1 of instruction in ID
id_rs2_addr  in  REG_ADDR_LEN  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
id_is_store  in  1  ID instruction is a store (rs2 is store data)
id_is_br  in  1  ID instruction is a conditional branch or JALR (not JAL)
id_do_branch  in  1  ID branch/jump taken, including JAL
id_ex_rd_addr  in  REG_ADDR_LEN  rd in ID/EX
id_ex_reg_write  in  1  ID/EX writes rd
id_ex_is_load  in  1  ID/EX is a load
mem_busy  in  1  data memory not ready this cycle
perf_clr  in  1  synchronous clear of all counters
pc_we  out  1  PC register update enable
pc_sel_branch  out  1  PC takes branch target
if_id_we  out  1  IF/ID update enable
if_id_flush  out  1  load BUBBLE into IF/ID
id_ex_bubble  out  1  zero ID/EX control signals
pipe_we  out  1  EX/MEM and MEM/WB update enable
stall_cnt  out  CNT_WIDTH  hazard-stall cycles
flush_cnt  out  CNT_WIDTH  taken-redirect flushes
freeze_cnt  out  CNT_WIDTH  mem_busy freeze cycles

Behaviour:
- FSM states: BOOT, RUN, LB_STALL. Reset: state=BOOT, boot counter=0, all counters=0.
- Outputs are combinational from state and inputs; state and counters are registered on the rising edge of clk.
- Hazard terms. A term never fires for rd=x0.
  - match1 = id_uses_rs1 & rs1==id_ex_rd
  - match2 = id_uses_rs2 & rs2==id_ex_rd
  - load_use = id_ex_is_load & (match1 | (match2 & !id_is_store)) & !id_is_br. The store-data case is forwarded in MEM.
  - load_br = id_ex_is_load & id_is_br & (match1|match2)
  - arith_br = id_ex_reg_write & !id_ex_is_load & id_is_br & (match1|match2)
- Priority, highest first:
  1. mem_busy: pc_we=if_id_we=pipe_we=0, id_ex_bubble=0, if_id_flush=0. State, boot count and pending stalls hold. freeze_cnt+1.
  2. BOOT: pc_we=1, pc_sel_branch=0, if_id_flush=1, id_ex_bubble=1, pipe_we=1. Count to BOOT_CYCLES-1, then go to RUN.
  3. LB_STALL: pc_we=0, if_id_we=0, id_ex_bubble=1, pipe_we=1; stall_cnt+1; next state RUN. id_do_branch is ignored in this state.
  4. RUN with load_br: same outputs as LB_STALL; stall_cnt+1; next state LB_STALL. Total stall is 2 cycles.
  5. RUN with load_use or arith_br: same outputs; stall_cnt+1; remain in RUN. Total stall is 1 cycle.
  6. RUN with id_do_branch: pc_we=1, pc_sel_branch=1, if_id_flush=1, id_ex_bubble=0; flush_cnt+1.
  7. Otherwise: all enables =1; flush and bubble =0.
- pc_sel_branch=0 whenever pc_we=0.
- Counters saturate at all-ones. perf_clr takes priority over increment in the same cycle.
- rst_n asserted mid-stall: immediate return to BOOT. The pending LB_STALL is discarded.

Decomposition:
- Shared package (core defines): REG_ADDR_LEN, REG_X0, state encoding (BOOT=2'd0, RUN=2'd1, LB_STALL=2'd2).
- One sub-module, sat_counter (CNT_WIDTH; inc, clr), instantiated three times.

Test Plan:
- Reset release with BOOT_CYCLES=2 → 2 cycles of if_id_flush=1 and pc_we=1, then RUN with all enables=1.
- lw x5 in EX, ID is add using rs1=x5 → exactly 1 cycle of pc_we=0 and id_ex_bubble=1; stall_cnt=1.
- lw x5 in EX, ID is beq x5,x6 → 2 consecutive stall cycles (RUN→LB_STALL→RUN); stall_cnt=2.
- addi x7 in EX, ID is bne x7 → 1-cycle stall. Same with rd=x0 → no stall.
- Taken beq with no hazard → pc_sel_branch=1 and if_id_flush=1 for one cycle; flush_cnt=1. Store sw x5 after lw x5 (rs2 only) → no stall.
- mem_busy held 3 cycles during LB_STALL → all enables 0 and state held; freeze_cnt=3; second stall cycle resumes afterwards. Counter preset near all-ones saturates. rst_n pulse mid-stall → BOOT and counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: register file addressing and FSM encoding.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDR_LEN = 5;
  localparam logic [REG_ADDR_LEN-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    LB_STALL = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter; clear wins over increment, holds at all-ones.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage core: combinational stage controls, registered
// FSM (boot warm-up, 2-cycle load->branch stall) and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_LEN = pipeline_hazard_ctrl_pkg::REG_ADDR_LEN,
  parameter int BOOT_CYCLES  = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [REG_ADDR_LEN-1:0] id_rs1_addr,
  input  logic [REG_ADDR_LEN-1:0] id_rs2_addr,
  input  logic                    id_uses_rs1,
  input  logic                    id_uses_rs2,
  input  logic                    id_is_store,
  input  logic                    id_is_br,
  input  logic                    id_do_branch,
  input  logic [REG_ADDR_LEN-1:0] id_ex_rd_addr,
  input  logic                    id_ex_reg_write,
  input  logic                    id_ex_is_load,
  input  logic                    mem_busy,
  input  logic                    perf_clr,
  output logic                    pc_we,
  output logic                    pc_sel_branch,
  output logic                    if_id_we,
  output logic                    if_id_flush,
  output logic                    id_ex_bubble,
  output logic                    pipe_we,
  output logic [CNT_WIDTH-1:0]    stall_cnt,
  output logic [CNT_WIDTH-1:0]    flush_cnt,
  output logic [CNT_WIDTH-1:0]    freeze_cnt
);

  import pipeline_hazard_ctrl_pkg::*;

  state_t     state_q, state_d;
  logic [3:0] boot_q, boot_d;

  logic rd_nz, match1, match2;
  logic load_use, load_br, arith_br;
  logic stall_inc, flush_inc, freeze_inc;

  assign rd_nz  = (id_ex_rd_addr != REG_ADDR_LEN'(REG_X0));
  assign match1 = rd_nz & id_uses_rs1 & (id_rs1_addr == id_ex_rd_addr);
  assign match2 = rd_nz & id_uses_rs2 & (id_rs2_addr == id_ex_rd_addr);

  // Store data only needs the loaded value in MEM, where it is forwarded.
  assign load_use = id_ex_is_load & (match1 | (match2 & ~id_is_store)) & ~id_is_br;
  assign load_br  = id_ex_is_load & id_is_br & (match1 | match2);
  assign arith_br = id_ex_reg_write & ~id_ex_is_load & id_is_br & (match1 | match2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      boot_q  <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    boot_d  = boot_q;
    if (!mem_busy) begin
      unique case (state_q)
        BOOT: begin
          boot_d = boot_q + 4'd1;
          if (boot_q == 4'(BOOT_CYCLES - 1)) state_d = RUN;
        end
        RUN:      if (load_br) state_d = LB_STALL;
        LB_STALL: state_d = RUN;
        default:  state_d = BOOT;
      endcase
    end
  end

  always_comb begin
    pc_we         = 1'b1;
    pc_sel_branch = 1'b0;
    if_id_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    pipe_we       = 1'b1;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    freeze_inc    = 1'b0;
    if (mem_busy) begin
      pc_we      = 1'b0;
      if_id_we   = 1'b0;
      pipe_we    = 1'b0;
      freeze_inc = 1'b1;
    end else begin
      unique case (state_q)
        BOOT: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
        LB_STALL: begin
          pc_we        = 1'b0;
          if_id_we     = 1'b0;
          id_ex_bubble = 1'b1;
          stall_inc    = 1'b1;
        end
        RUN: begin
          if (load_br | load_use | arith_br) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
          end else if (id_do_branch) begin
            pc_sel_branch = 1'b1;
            if_id_flush   = 1'b1;
            flush_inc     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(stall_inc), .clr(perf_clr), .count(stall_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(flush_inc), .clr(perf_clr), .count(flush_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_freeze_cnt (
    .clk(clk), .rst_n(rst_n), .inc(freeze_inc), .clr(perf_clr), .count(freeze_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: a full-width controller plus a 2-bit-counter copy sharing all inputs.
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] NORM  = 6'b101001;
  localparam logic [5:0] STALL = 6'b000011;
  localparam logic [5:0] BR    = 6'b111101;
  localparam logic [5:0] FRZ   = 6'b000000;
  localparam logic [5:0] BOOTO = 6'b101111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_ex_rd_addr;
  logic       id_uses_rs1, id_uses_rs2, id_is_store, id_is_br, id_do_branch;
  logic       id_ex_reg_write, id_ex_is_load, mem_busy, perf_clr;

  logic        pc_we, pc_sel_branch, if_id_we, if_id_flush, id_ex_bubble, pipe_we;
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
  logic        s_pc_we, s_pc_sel_branch, s_if_id_we, s_if_id_flush, s_id_ex_bubble, s_pipe_we;
  logic [1:0]  s_stall_cnt, s_flush_cnt, s_freeze_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_LEN(5), .BOOT_CYCLES(2), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_is_store(id_is_store), .id_is_br(id_is_br), .id_do_branch(id_do_branch),
    .id_ex_rd_addr(id_ex_rd_addr), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_is_load(id_ex_is_load), .mem_busy(mem_busy), .perf_clr(perf_clr),
    .pc_we(pc_we), .pc_sel_branch(pc_sel_branch), .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .pipe_we(pipe_we),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_LEN(5), .BOOT_CYCLES(2), .CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_is_store(id_is_store), .id_is_br(id_is_br), .id_do_branch(id_do_branch),
    .id_ex_rd_addr(id_ex_rd_addr), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_is_load(id_ex_is_load), .mem_busy(mem_busy), .perf_clr(perf_clr),
    .pc_we(s_pc_we), .pc_sel_branch(s_pc_sel_branch), .if_id_we(s_if_id_we),
    .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble), .pipe_we(s_pipe_we),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .freeze_cnt(s_freeze_cnt)
  );

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, st, br, dob, rw, ld, busy;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(string n, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic st, logic br, logic dob, logic [4:0] rd, logic rw,
                              logic ld, logic busy, logic [5:0] exp);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.st = st; v.br = br;
    v.dob = dob; v.rd = rd; v.rw = rw; v.ld = ld; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  task automatic apply(vec_t v);
    id_rs1_addr = v.rs1; id_rs2_addr = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    id_is_store = v.st; id_is_br = v.br; id_do_branch = v.dob; id_ex_rd_addr = v.rd;
    id_ex_reg_write = v.rw; id_ex_is_load = v.ld; mem_busy = v.busy;
  endtask

  task automatic idle();
    apply(mk("idle", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM));
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {pc_we, pc_sel_branch, if_id_we, if_id_flush, id_ex_bubble, pipe_we};
  endfunction

  // Called just after a rising edge: check combinational outputs mid-cycle, then advance.
  task automatic step_chk(string name, logic [5:0] exp);
    @(negedge clk);
    chk(name, {26'd0, outs()}, {26'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t load_use_v, load_br_v;

    vecs[0]  = mk("v_idle",       5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0, NORM);
    vecs[1]  = mk("v_load_use",   5'd5, 5'd1, 1, 1, 0, 0, 0, 5'd5, 1, 1, 0, STALL);
    vecs[2]  = mk("v_store_data", 5'd1, 5'd5, 1, 1, 1, 0, 0, 5'd5, 1, 1, 0, NORM);
    vecs[3]  = mk("v_load_rs2",   5'd1, 5'd5, 1, 1, 0, 0, 0, 5'd5, 1, 1, 0, STALL);
    vecs[4]  = mk("v_arith_br",   5'd7, 5'd2, 1, 1, 0, 1, 0, 5'd7, 1, 0, 0, STALL);
    vecs[5]  = mk("v_arith_br_x0",5'd0, 5'd2, 1, 1, 0, 1, 0, 5'd0, 1, 0, 0, NORM);
    vecs[6]  = mk("v_load_x0",    5'd0, 5'd0, 1, 1, 0, 0, 0, 5'd0, 1, 1, 0, NORM);
    vecs[7]  = mk("v_taken_br",   5'd3, 5'd4, 1, 1, 0, 1, 1, 5'd9, 1, 0, 0, BR);
    vecs[8]  = mk("v_stall_wins", 5'd7, 5'd2, 1, 1, 0, 1, 1, 5'd7, 1, 0, 0, STALL);
    vecs[9]  = mk("v_alu_fwd",    5'd8, 5'd2, 1, 1, 0, 0, 0, 5'd8, 1, 0, 0, NORM);
    vecs[10] = mk("v_busy",       5'd5, 5'd1, 1, 1, 0, 0, 0, 5'd5, 1, 1, 1, FRZ);
    vecs[11] = mk("v_rs1_unused", 5'd5, 5'd1, 0, 1, 0, 0, 0, 5'd5, 1, 1, 0, NORM);
    vecs[12] = mk("v_jal",        5'd5, 5'd5, 0, 0, 0, 0, 1, 5'd5, 1, 1, 0, BR);
    load_use_v = vecs[1];
    load_br_v  = mk("lb", 5'd5, 5'd6, 1, 1, 0, 1, 0, 5'd5, 1, 1, 0, STALL);

    rst_n = 1'b0;
    perf_clr = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {26'd0, outs()}, {26'd0, BOOTO});
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_freeze_cnt", freeze_cnt, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    chk("boot0", {26'd0, outs()}, {26'd0, BOOTO});
    tick();
    step_chk("boot1", BOOTO);
    step_chk("run_first", NORM);

    foreach (vecs[i]) begin
      apply(vecs[i]);
      step_chk(vecs[i].name, vecs[i].exp);
    end
    idle();
    chk("tbl_stall_cnt", stall_cnt, 32'd4);
    chk("tbl_flush_cnt", flush_cnt, 32'd2);
    chk("tbl_freeze_cnt", freeze_cnt, 32'd1);
    chk("small_stall_sat", {30'd0, s_stall_cnt}, 32'd3);

    // Clear beats a simultaneous increment.
    apply(load_use_v);
    perf_clr = 1'b1;
    step_chk("clr_stall_outs", STALL);
    perf_clr = 1'b0;
    idle();
    chk("clr_stall_cnt", stall_cnt, 32'd0);
    chk("clr_flush_cnt", flush_cnt, 32'd0);

    apply(load_use_v);
    step_chk("lu_stall", STALL);
    idle();
    step_chk("lu_after", NORM);
    chk("lu_stall_cnt", stall_cnt, 32'd1);

    apply(load_br_v);
    step_chk("lb_stall1", STALL);
    idle();
    id_do_branch = 1'b1;
    step_chk("lb_stall2_ignores_br", STALL);
    step_chk("lb_then_branch", BR);
    idle();
    chk("lb_stall_cnt", stall_cnt, 32'd3);
    chk("lb_flush_cnt", flush_cnt, 32'd1);

    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    apply(load_br_v);
    step_chk("fz_stall1", STALL);
    idle();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) step_chk($sformatf("fz_hold%0d", i), FRZ);
    mem_busy = 1'b0;
    step_chk("fz_resume_stall2", STALL);
    step_chk("fz_run", NORM);
    chk("fz_freeze_cnt", freeze_cnt, 32'd3);
    chk("fz_stall_cnt", stall_cnt, 32'd2);
    mem_busy = 1'b1;
    step_chk("fz_more0", FRZ);
    step_chk("fz_more1", FRZ);
    mem_busy = 1'b0;
    chk("fz_freeze_cnt5", freeze_cnt, 32'd5);
    chk("small_freeze_sat", {30'd0, s_freeze_cnt}, 32'd3);

    apply(load_br_v);
    step_chk("rs_stall1", STALL);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_mid_outs", {26'd0, outs()}, {26'd0, BOOTO});
    chk("rs_mid_stall_cnt", stall_cnt, 32'd0);
    chk("rs_mid_freeze_cnt", freeze_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rs_boot0", {26'd0, outs()}, {26'd0, BOOTO});
    tick();
    step_chk("rs_boot1", BOOTO);
    step_chk("rs_run", NORM);
    chk("rs_stall_cnt", stall_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
